// File: rtl/branch_predictor_gshare_spec.sv
// ============================================================================
// branch_predictor_gshare_spec : parametrised gshare predictor, speculative
// history with snapshot repair, init walk, mispredict counter.  Rev 1.0
// ============================================================================
`default_nettype none

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package mips_core_pkg;
  typedef enum logic {NOT_TAKEN = 1'b0, TAKEN = 1'b1} BranchOutcome;
endpackage

module branch_predictor_gshare_spec #(
  parameter int GHR_BITS   = 8,
  parameter int INDEX_BITS = 10,
  parameter int CTR_BITS   = 2,
  parameter int PC_LSB     = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_req_valid,
  input  logic [`ADDR_WIDTH-1:0]        i_req_pc,
  input  logic [`ADDR_WIDTH-1:0]        i_req_target,
  output mips_core_pkg::BranchOutcome   o_req_prediction,
  output logic [GHR_BITS-1:0]           o_req_ghr,
  output logic                          o_init_done,
  input  logic                          i_fb_valid,
  input  logic [`ADDR_WIDTH-1:0]        i_fb_pc,
  input  mips_core_pkg::BranchOutcome   i_fb_prediction,
  input  mips_core_pkg::BranchOutcome   i_fb_outcome,
  input  logic [GHR_BITS-1:0]           i_fb_ghr,
  output logic [31:0]                   o_mispredict_count
);
  import mips_core_pkg::*;

  localparam int                    c_depth    = 2 ** INDEX_BITS;
  localparam logic [CTR_BITS-1:0]   c_ctr_wt   = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0]   c_ctr_max  = {CTR_BITS{1'b1}};
  localparam logic [INDEX_BITS-1:0] c_last_idx = {INDEX_BITS{1'b1}};

  typedef enum logic [0:0] {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [INDEX_BITS-1:0]   r_init_ptr;
  logic [CTR_BITS-1:0]     r_pht [c_depth];
  logic [GHR_BITS-1:0]     r_ghr;
  logic [31:0]             r_count;

  logic                    w_run;
  logic [INDEX_BITS-1:0]   w_req_idx;
  logic [INDEX_BITS-1:0]   w_fb_idx;
  logic [CTR_BITS-1:0]     w_req_ctr;
  logic [CTR_BITS-1:0]     w_fb_ctr;
  logic [CTR_BITS-1:0]     w_fb_ctr_nxt;
  logic                    w_pred_taken;
  logic                    w_fb_taken;
  logic                    w_mispredict;
  logic [GHR_BITS-1:0]     w_req_shift;
  logic [GHR_BITS-1:0]     w_fb_shift;
  logic                    w_unused;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_INIT;
      r_init_ptr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_INIT) r_init_ptr <= r_init_ptr + INDEX_BITS'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_INIT && r_init_ptr == c_last_idx) w_state_nxt = S_RUN;
  end

  assign w_run     = (r_state == S_RUN);
  assign w_req_idx = i_req_pc[PC_LSB +: INDEX_BITS] ^ INDEX_BITS'(r_ghr);
  assign w_fb_idx  = i_fb_pc[PC_LSB +: INDEX_BITS] ^ INDEX_BITS'(i_fb_ghr);
  assign w_req_ctr = r_pht[w_req_idx];
  assign w_fb_ctr  = r_pht[w_fb_idx];

  assign w_pred_taken = w_run & w_req_ctr[CTR_BITS-1];
  assign w_fb_taken   = (i_fb_outcome == TAKEN);
  assign w_mispredict = w_run & i_fb_valid & (i_fb_prediction != i_fb_outcome);

  always_comb begin
    w_fb_ctr_nxt = w_fb_ctr;
    if (w_fb_taken && w_fb_ctr != c_ctr_max)
      w_fb_ctr_nxt = w_fb_ctr + CTR_BITS'(1);
    else if (!w_fb_taken && w_fb_ctr != '0)
      w_fb_ctr_nxt = w_fb_ctr - CTR_BITS'(1);
  end

  // No reset on the table: the init walk is what clears it.
  always_ff @(posedge clk) begin
    if (!w_run)
      r_pht[r_init_ptr] <= c_ctr_wt;
    else if (i_fb_valid)
      r_pht[w_fb_idx] <= w_fb_ctr_nxt;
  end

  generate
    if (GHR_BITS == 1) begin : g_ghr_one
      assign w_req_shift = w_pred_taken;
      assign w_fb_shift  = w_fb_taken;
    end else begin : g_ghr_wide
      assign w_req_shift = {r_ghr[GHR_BITS-2:0], w_pred_taken};
      assign w_fb_shift  = {i_fb_ghr[GHR_BITS-2:0], w_fb_taken};
    end
  endgenerate

  // Recovery from the branch's own snapshot overrides any same-cycle shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ghr   <= '0;
      r_count <= '0;
    end else begin
      if (w_mispredict)
        r_ghr <= w_fb_shift;
      else if (w_run && i_req_valid)
        r_ghr <= w_req_shift;
      if (w_mispredict && r_count != 32'hFFFF_FFFF)
        r_count <= r_count + 32'd1;
    end
  end

  assign o_req_prediction   = w_pred_taken ? TAKEN : NOT_TAKEN;
  assign o_req_ghr          = r_ghr;
  assign o_init_done        = w_run;
  assign o_mispredict_count = r_count;

  assign w_unused = &{1'b0, i_req_target, i_req_pc, i_fb_pc, i_fb_ghr};

endmodule

`default_nettype wire
